// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data RAM core and its lane decoder.
//   size_e   : access-size encodings carried on req_size
//   state_e  : controller states (CLEAR = zero-fill sweep, RUN = serving)
//   is_misaligned() : alignment rule shared by store and load paths
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // A request is rejected when it straddles its natural boundary or uses
    // the reserved size code; bytes can never be misaligned.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_ram_lane_align.sv
// ---------------------------------------------------------------------------
// lane_align
// Purely combinational byte-lane steering for a 32-bit little-endian word.
// Ports:
//   size        in  access size (mem_pkg::size_e encoding)
//   zero_ext    in  1 = zero-extend loads, 0 = sign-extend
//   addr_lo     in  byte offset within the word
//   wdata       in  store data, taken from its low-order bits
//   old_word    in  current contents of the addressed word
//   byte_en     out lanes written by a store (all zero on error)
//   merged_word out old_word with the enabled lanes replaced
//   load_data   out extracted and extended load result (zero on error)
//   err         out misaligned access or reserved size
// ---------------------------------------------------------------------------
module lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [3:0]  byte_en,
    output logic [31:0] merged_word,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] lane_data;
    logic [15:0] sel;

    // Store side: replicate the store data across all lanes so the enable
    // mask alone decides which lanes pick it up, then merge with old data.
    always_comb begin
        err       = is_misaligned(size_e'(size), addr_lo);
        byte_en   = 4'b0000;
        lane_data = wdata;
        case (size_e'(size))
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                lane_data = wdata;
            end
        endcase
        if (err) begin
            byte_en = 4'b0000;
        end
        for (int i = 0; i < 4; i++) begin
            merged_word[8*i +: 8] = byte_en[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    // Load side: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        sel       = 16'(old_word >> {addr_lo, 3'b000});
        load_data = 32'h0;
        case (size_e'(size))
            SIZE_BYTE: load_data = zero_ext ? {24'h0, sel[7:0]}  : {{24{sel[7]}}, sel[7:0]};
            SIZE_HALF: load_data = zero_ext ? {16'h0, sel[15:0]} : {{16{sel[15]}}, sel[15:0]};
            SIZE_WORD: load_data = old_word;
            default:   load_data = 32'h0;
        endcase
        if (err) begin
            load_data = 32'h0;
        end
    end

endmodule

// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
// Single-port byte-addressable data memory with one request per cycle and a
// fixed one-cycle response. Optionally zero-fills itself after reset.
// Parameters:
//   DEPTH_WORDS    number of 32-bit words (power of two, >= 4)
//   ADDR_W         byte-address width
//   CLEAR_ON_RESET 1 = sweep zeros through every word after reset
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready low only while clearing)
//   req_write      1 = store, 0 = load
//   req_size       0 byte, 1 half, 2 word, 3 reserved
//   req_unsigned   zero-extend loads when 1
//   req_addr       byte address (upper bits beyond the array alias)
//   req_wdata      store data
//   rsp_valid      one-cycle pulse, one cycle after acceptance
//   rsp_data       load result, 0 for stores and errors
//   rsp_err        misaligned access or reserved size
//   busy           clear sweep in progress
// ---------------------------------------------------------------------------
module data_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 2048,
    parameter int ADDR_W         = 24,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
    localparam state_e           RST_ST   = CLEAR_ON_RESET ? CLEAR : RUN;

    logic [31:0]      mem [0:DEPTH_WORDS-1];
    state_e           state;
    state_e           state_next;
    logic [IDX_W-1:0] clr_cnt;
    logic [IDX_W-1:0] word_idx;
    logic             accept;
    logic             store_en;
    logic [31:0]      old_word;
    logic [3:0]       byte_en;
    logic [31:0]      merged_word;
    logic [31:0]      load_data;
    logic             acc_err;
    logic             unused_addr_hi;

    // Address bits above the array are deliberately ignored, so the array
    // aliases across the whole byte-address space.
    assign word_idx       = req_addr[IDX_W+1:2];
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    assign req_ready = (state == RUN);
    assign busy      = (state == CLEAR);
    assign accept    = req_valid && req_ready;
    assign old_word  = mem[word_idx];
    assign store_en  = accept && req_write && (|byte_en);

    lane_align u_lane_align (
        .size        (req_size),
        .zero_ext    (req_unsigned),
        .addr_lo     (req_addr[1:0]),
        .wdata       (req_wdata),
        .old_word    (old_word),
        .byte_en     (byte_en),
        .merged_word (merged_word),
        .load_data   (load_data),
        .err         (acc_err)
    );

    // State register and clear-sweep counter. Reset always restarts the
    // sweep from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_ST;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + IDX_W'(1);
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // Leave CLEAR on the same edge that zeroes the last word.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_cnt == LAST_IDX) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RST_ST;
        endcase
    end

    // Memory array: no reset. Writes come either from the clear sweep or
    // from an accepted, well-formed store carrying the merged word. Reads
    // are asynchronous so a load right after a store sees the new data.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= 32'h0;
        end else if (store_en) begin
            mem[word_idx] <= merged_word;
        end
    end

    // Response register: one pulse per accepted request, data only for
    // successful loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && acc_err;
            rsp_data  <= (accept && !req_write) ? load_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// ---------------------------------------------------------------------------
// tb_data_ram
// Directed self-checking bench for data_ram with DEPTH_WORDS=16 and
// CLEAR_ON_RESET=1. Inputs change on falling edges; outputs are sampled on
// falling edges.
// ---------------------------------------------------------------------------
module tb_data_ram;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int checks;
    int passed;

    data_ram #(
        .DEPTH_WORDS    (16),
        .ADDR_W         (24),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request at the current falling edge, let the next rising edge
    // accept it, and return at the following falling edge with the response
    // on the outputs and req_valid dropped.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [23:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count falling edges until busy drops, bounded.
    task automatic wait_clear(output int cycles, output logic stray);
        cycles = 0;
        stray  = 1'b0;
        while (busy && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid) stray = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_unsigned = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy got %b want 1", busy); else passed++;
        checks++; if (req_ready !== 1'b0) $display("[TB] FAIL reset_ready got %b want 0", req_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL reset_rsp_err got %b want 0", rsp_err); else passed++;
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL reset_rsp_data got %h want 00000000", rsp_data); else passed++;
    endtask

    task automatic test_clear();
        int   cycles;
        logic stray;
        // A request held during the sweep must be ignored.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 24'h3C;
        rst_n     = 1'b1;
        wait_clear(cycles, stray);
        req_valid = 1'b0;
        checks++; if (cycles != 16) $display("[TB] FAIL clear_busy_cycles got %0d want 16", cycles); else passed++;
        checks++; if (stray !== 1'b0) $display("[TB] FAIL clear_ignored_req got rsp_valid during clear, want none"); else passed++;
        checks++; if (req_ready !== 1'b1) $display("[TB] FAIL clear_ready_after got %b want 1", req_ready); else passed++;
        issue(1'b0, 2'd2, 1'b0, 24'h3C, 32'h0);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL clear_load_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL clear_load_3c got %h want 00000000", rsp_data); else passed++;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL clear_pulse_width got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_byte_store();
        issue(1'b1, 2'd2, 1'b0, 24'h10, 32'h11223344);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL store_word_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL store_word_data got %h want 00000000", rsp_data); else passed++;
        issue(1'b1, 2'd0, 1'b0, 24'h12, 32'h123456AA);
        checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL store_byte_err got %b want 0", rsp_err); else passed++;
        issue(1'b0, 2'd2, 1'b0, 24'h10, 32'h0);
        checks++; if (rsp_data !== 32'h11AA3344) $display("[TB] FAIL byte_merge got %h want 11aa3344", rsp_data); else passed++;
        // Half store into the upper lanes of a cleared word.
        issue(1'b1, 2'd1, 1'b0, 24'h1A, 32'h1234BEEF);
        issue(1'b0, 2'd2, 1'b0, 24'h18, 32'h0);
        checks++; if (rsp_data !== 32'hBEEF0000) $display("[TB] FAIL half_merge got %h want beef0000", rsp_data); else passed++;
    endtask

    task automatic test_load_extend();
        issue(1'b0, 2'd0, 1'b0, 24'h12, 32'h0);
        checks++; if (rsp_data !== 32'hFFFFFFAA) $display("[TB] FAIL lb_signed got %h want ffffffaa", rsp_data); else passed++;
        issue(1'b0, 2'd0, 1'b1, 24'h12, 32'h0);
        checks++; if (rsp_data !== 32'h000000AA) $display("[TB] FAIL lb_unsigned got %h want 000000aa", rsp_data); else passed++;
        issue(1'b0, 2'd1, 1'b0, 24'h12, 32'h0);
        checks++; if (rsp_data !== 32'h000011AA) $display("[TB] FAIL lh_signed_12 got %h want 000011aa", rsp_data); else passed++;
        issue(1'b0, 2'd0, 1'b1, 24'h13, 32'h0);
        checks++; if (rsp_data !== 32'h00000011) $display("[TB] FAIL lbu_13 got %h want 00000011", rsp_data); else passed++;
        issue(1'b0, 2'd1, 1'b0, 24'h1A, 32'h0);
        checks++; if (rsp_data !== 32'hFFFFBEEF) $display("[TB] FAIL lh_signed_1a got %h want ffffbeef", rsp_data); else passed++;
        issue(1'b0, 2'd1, 1'b1, 24'h1A, 32'h0);
        checks++; if (rsp_data !== 32'h0000BEEF) $display("[TB] FAIL lhu_1a got %h want 0000beef", rsp_data); else passed++;
    endtask

    task automatic test_misalign();
        issue(1'b1, 2'd2, 1'b0, 24'h20, 32'h55667788);
        issue(1'b1, 2'd2, 1'b0, 24'h21, 32'hDEADBEEF);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL misalign_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_err !== 1'b1) $display("[TB] FAIL misalign_err got %b want 1", rsp_err); else passed++;
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL misalign_data got %h want 00000000", rsp_data); else passed++;
        issue(1'b0, 2'd2, 1'b0, 24'h20, 32'h0);
        checks++; if (rsp_data !== 32'h55667788) $display("[TB] FAIL misalign_nowrite got %h want 55667788", rsp_data); else passed++;
        checks++; if (rsp_err !== 1'b0) $display("[TB] FAIL aligned_err got %b want 0", rsp_err); else passed++;
        issue(1'b0, 2'd1, 1'b0, 24'h11, 32'h0);
        checks++; if ({rsp_err, rsp_data} !== {1'b1, 32'h0}) $display("[TB] FAIL odd_half_load got err=%b data=%h want err=1 data=00000000", rsp_err, rsp_data); else passed++;
        issue(1'b1, 2'd3, 1'b0, 24'h20, 32'hFFFFFFFF);
        checks++; if (rsp_err !== 1'b1) $display("[TB] FAIL rsvd_size_err got %b want 1", rsp_err); else passed++;
        issue(1'b0, 2'd2, 1'b0, 24'h20, 32'h0);
        checks++; if (rsp_data !== 32'h55667788) $display("[TB] FAIL rsvd_nowrite got %h want 55667788", rsp_data); else passed++;
    endtask

    task automatic test_back_to_back();
        // Cycle n: store; cycle n+1: load of the same word.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_unsigned = 1'b0;
        req_addr  = 24'h8;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL b2b_first_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL b2b_first_data got %h want 00000000", rsp_data); else passed++;
        req_write = 1'b0;
        req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) $display("[TB] FAIL b2b_second_valid got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_data !== 32'hCAFEF00D) $display("[TB] FAIL b2b_second_data got %h want cafef00d", rsp_data); else passed++;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL b2b_idle_after got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_aliasing();
        // With 16 words, 0x44 wraps onto word 1 (byte 0x4).
        issue(1'b1, 2'd2, 1'b0, 24'hF00044, 32'hA5A55A5A);
        issue(1'b0, 2'd2, 1'b0, 24'h000004, 32'h0);
        checks++; if (rsp_data !== 32'hA5A55A5A) $display("[TB] FAIL alias_load got %h want a5a55a5a", rsp_data); else passed++;
    endtask

    task automatic test_reset_mid_op();
        int   cycles;
        logic stray;
        issue(1'b1, 2'd2, 1'b0, 24'h3C, 32'h0BADF00D);
        issue(1'b0, 2'd2, 1'b0, 24'h3C, 32'h0);
        checks++; if (rsp_data !== 32'h0BADF00D) $display("[TB] FAIL premid_load got %h want 0badf00d", rsp_data); else passed++;
        // Load accepted on the next rising edge, reset asserted just after.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 24'h3C;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL midreset_rsp_valid got %b want 0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL midreset_busy got %b want 1", busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear(cycles, stray);
        checks++; if (cycles != 16) $display("[TB] FAIL reclear_cycles got %0d want 16", cycles); else passed++;
        checks++; if (stray !== 1'b0) $display("[TB] FAIL reclear_stray_rsp got rsp_valid during clear, want none"); else passed++;
        issue(1'b0, 2'd2, 1'b0, 24'h3C, 32'h0);
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL reclear_3c got %h want 00000000", rsp_data); else passed++;
        issue(1'b0, 2'd2, 1'b0, 24'h08, 32'h0);
        checks++; if (rsp_data !== 32'h0) $display("[TB] FAIL reclear_08 got %h want 00000000", rsp_data); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_clear();
        test_byte_store();
        test_load_extend();
        test_misalign();
        test_back_to_back();
        test_aliasing();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 2048, meaning the number of 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter ADDR_W, default 24, meaning the byte-address width.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all words after reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted this cycle if req_valid.
REQ-008 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-011 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-012 SHALL have port req_wdata, input, 32, store data, taken from its low-order bits.
REQ-013 SHALL have port rsp_valid, output, 1, a one-cycle response pulse.
REQ-014 SHALL have port rsp_data, output, 32, load result; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, request rejected (misaligned or reserved size).
REQ-016 SHALL have port busy, output, 1, clear sequence in progress.

Function
REQ-017 SHALL form the word index from req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored (aliasing).
REQ-018 SHALL accept a request on a cycle where req_valid and req_ready are both 1.
REQ-019 SHALL assert rsp_valid exactly one cycle after acceptance, for exactly one cycle, for both loads and stores.
REQ-020 SHALL hold req_ready at 1 in every RUN cycle, giving one request per cycle with no response back-pressure.
REQ-021 SHALL store: word overwrites all 4 lanes; half writes lanes {addr[1],0..1}; byte writes lane addr[1:0]; all other lanes are preserved.
REQ-022 SHALL load: select lane(s) per addr[1:0] and size, then sign- or zero-extend to 32 bits per req_unsigned.
REQ-023 SHALL treat a half at odd address, a word with addr[1:0]≠0, or size 3 as an error: no memory write, rsp_err=1, rsp_data=0.
REQ-024 SHALL, for a load on the cycle after a store to the same word, return the newly stored data.
REQ-025 SHALL implement the FSM states CLEAR and RUN.
REQ-026 SHALL, in CLEAR, write 0 to the word at a counter address each cycle, starting at 0, with req_ready=0 and busy=1.
REQ-027 SHALL transition CLEAR→RUN on the cycle the counter writes DEPTH_WORDS-1; busy drops in that same transition.
REQ-028 SHALL enter RUN directly from reset when CLEAR_ON_RESET=0; memory contents are then undefined.
REQ-029 SHALL ignore req_valid while req_ready=0 and produce no response for it.

Reset
REQ-030 SHALL, while rst_n is low, drive rsp_valid=0, rsp_err=0, rsp_data=0 and clear counter=0.
REQ-031 SHALL, while rst_n is low, drive state=CLEAR, busy=1, req_ready=0 if CLEAR_ON_RESET=1.
REQ-032 SHALL, while rst_n is low, drive state=RUN, busy=0, req_ready=1 if CLEAR_ON_RESET=0.
REQ-033 SHALL, on reset during an accepted request, drop the pending response; on reset during CLEAR, restart the clear from word 0.
REQ-034 SHALL NOT reset the memory array itself asynchronously.

Structure
REQ-035 SHALL place the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) in shared package mem_pkg, for reuse by the core and the memory decoder.
REQ-036 SHALL use one sub-module, lane_align: combinational store merge/byte-enable generation plus load extract/extend, instantiated once.

Verification
REQ-037 SHALL cover clear: DEPTH_WORDS=16, CLEAR_ON_RESET=1, release reset -> busy=1 for 16 cycles, then req_ready=1; word load at 0x3C -> 0x00000000.
REQ-038 SHALL cover byte store: store word 0x11223344 @0x10, then byte 0xAA @0x12 -> word load @0x10 = 0x11AA3344.
REQ-039 SHALL cover load extend: after REQ-038, signed byte load @0x12 -> 0xFFFFFFAA; unsigned -> 0x000000AA; signed half @0x12 -> 0x000011AA.
REQ-040 SHALL cover misalignment: word store 0xDEADBEEF @0x21 -> rsp_err=1, rsp_data=0; word load @0x20 unchanged.
REQ-041 SHALL cover back-to-back: store 0xCAFEF00D @0x8 on cycle n, load @0x8 on cycle n+1 -> rsp_valid on n+1 and n+2, second rsp_data=0xCAFEF00D.
REQ-042 SHALL cover reset mid-op: assert rst_n low the cycle after a load is accepted -> no rsp_valid; busy=1 again and clear restarts from word 0.
